// File: rtl/arb_pkg.sv
// Shared state type and default sizing for the round-robin arbiter.
package arb_pkg;
  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} arb_state_t;

  localparam int ARB_N              = 1024;
  localparam int ARB_W              = $clog2(ARB_N);
  localparam int ARB_TIMEOUT_CYCLES = 256;
endpackage

// File: rtl/rr_prio_enc.sv
// Combinational lowest-set-bit priority encoder with an any-request flag.
module rr_prio_enc import arb_pkg::*; #(
  parameter int N = ARB_N,
  parameter int W = ARB_W
) (
  input  logic [N-1:0] i_req,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  // Scanning downward leaves the lowest set index as the final assignment.
  always_comb begin
    o_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = W'(i);
    end
  end

  assign o_any = |i_req;

endmodule

// File: rtl/rr_arbiter_1024.sv
// Round-robin arbiter for up to N requesters with registered grant outputs.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_1024 import arb_pkg::*; #(
  parameter int N              = ARB_N,
  parameter int W              = $clog2(N),
  parameter int TIMEOUT_CYCLES = ARB_TIMEOUT_CYCLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_idx,
  output logic [N-1:0] gnt_onehot,
  output logic         busy
`ifdef ARB_TIMEOUT_EN
  ,
  output logic         timeout
`endif
);

  arb_state_t   r_state, w_state_nxt;
  logic [W-1:0] r_gnt_idx, r_last_idx;
  logic [W-1:0] w_idx_m, w_idx_u, w_winner;
  logic [N-1:0] r_gnt_onehot, w_mask, w_req_m;
  logic         w_any_m, w_any_u;
  logic         w_grant, w_release, w_expire;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  // Only indices strictly above the previous winner are eligible first.
  always_comb begin
    w_mask = '0;
    for (int i = 0; i < N; i++) begin
      w_mask[i] = (i > int'(r_last_idx));
    end
  end

  assign w_req_m = req & w_mask;

  rr_prio_enc #(.N(N), .W(W)) u_enc_masked (
    .i_req (w_req_m),
    .o_idx (w_idx_m),
    .o_any (w_any_m)
  );

  rr_prio_enc #(.N(N), .W(W)) u_enc_unmasked (
    .i_req (req),
    .o_idx (w_idx_u),
    .o_any (w_any_u)
  );

  assign w_winner = w_any_m ? w_idx_m : w_idx_u;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_any_u) begin
          w_state_nxt = GRANT;
          w_grant     = 1'b1;
        end
      end
      GRANT: begin
        if (done || w_expire) begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_gnt_idx    <= '0;
      r_gnt_onehot <= '0;
      r_last_idx   <= W'(N - 1);
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_gnt_idx    <= w_winner;
        r_gnt_onehot <= {{(N-1){1'b0}}, 1'b1} << w_winner;
      end else if (w_release) begin
        r_last_idx   <= r_gnt_idx;
        r_gnt_onehot <= '0;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_timeout;

  // done in the limit cycle takes precedence, so expiry requires !done.
  assign w_expire = (r_state == GRANT) && !done &&
                    (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_grant) r_cnt <= '0;
      else if (r_state == GRANT) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  assign w_expire = 1'b0;
`endif

  assign gnt_valid  = (r_state == GRANT);
  assign busy       = (r_state == GRANT);
  assign gnt_idx    = r_gnt_idx;
  assign gnt_onehot = r_gnt_onehot;

endmodule

// File: tb/tb_rr_arbiter_1024.sv
// Self-checking bench for rr_arbiter_1024: directed scenarios plus random traffic vs. a rotation model.
module tb_rr_arbiter_1024;
  localparam int N = 1024;
  localparam int W = 10;
`ifdef ARB_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 256;
`endif

  logic         clk = 1'b0;
  logic         rst, done;
  logic [N-1:0] req;
  logic         gnt_valid, busy;
  logic [W-1:0] gnt_idx;
  logic [N-1:0] gnt_onehot;
`ifdef ARB_TIMEOUT_EN
  logic         timeout;
`endif

  int total = 0;
  int bad   = 0;
  bit cmp_en = 1'b0;

  bit           m_valid, m_to;
  int           m_idx, m_last, m_age;
  logic [N-1:0] exp_oh;

  always #5 clk = ~clk;

  rr_arbiter_1024 #(.N(N), .W(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .done       (done),
    .gnt_valid  (gnt_valid),
    .gnt_idx    (gnt_idx),
    .gnt_onehot (gnt_onehot),
    .busy       (busy)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout    (timeout)
`endif
  );

  function automatic int rr_pick(input logic [N-1:0] r, input int last);
    for (int j = 1; j <= N; j++) begin
      int c;
      c = (last + j) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic int low_bit(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_oh(input string nm, input logic [N-1:0] act, input logic [N-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual ones=%0d low=%0d required ones=%0d low=%0d at %0t",
               nm, $countones(act), low_bit(act), $countones(exp), low_bit(exp), $time);
    end
  endtask

  // Reference: rotate from the last winner, hold until done (or watchdog expiry).
  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1'b0; m_idx = 0; m_last = N - 1; m_age = 0; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (!m_valid) begin
        if (req != '0) begin
          m_idx = rr_pick(req, m_last); m_valid = 1'b1; m_age = 1;
        end
      end else begin
        if (done) begin
          m_last = m_idx; m_valid = 1'b0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (m_age >= TO) begin
          m_last = m_idx; m_valid = 1'b0; m_to = 1'b1;
        end
`endif
        else m_age++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_oh = '0;
      if (m_valid) exp_oh[m_idx] = 1'b1;
      chk("model_valid", gnt_valid, m_valid);
      chk("model_busy", busy, m_valid);
      if (m_valid) chk("model_idx", gnt_idx, m_idx);
      chk_oh("model_onehot", gnt_onehot, exp_oh);
`ifdef ARB_TIMEOUT_EN
      chk("model_timeout", timeout, m_to);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = 1'b0;
    step(); step();
    rst = 1'b0;
  endtask

  task automatic expect_grant(input string nm, input int idx);
    logic [N-1:0] oh;
    oh = '0; oh[idx] = 1'b1;
    chk({nm, "_valid"}, gnt_valid, 1);
    chk({nm, "_idx"}, gnt_idx, idx);
    chk_oh({nm, "_onehot"}, gnt_onehot, oh);
  endtask

  task automatic release_grant(input string nm);
    done = 1'b1; step(); done = 1'b0;
    chk({nm, "_released"}, gnt_valid, 0);
  endtask

  initial begin
    int seq[4];
    rst = 1'b1; req = '0; done = 1'b0;
    do_reset();
    chk("reset_valid", gnt_valid, 0);
    chk("reset_idx", gnt_idx, 0);
    chk_oh("reset_onehot", gnt_onehot, '0);
    chk("reset_busy", busy, 0);
`ifdef ARB_TIMEOUT_EN
    chk("reset_timeout", timeout, 0);
`endif
    cmp_en = 1'b1;

    // Single requester grant and release.
    req[5] = 1'b1; step();
    expect_grant("single5", 5);
    req = '0; release_grant("single5");

    // Held requests rotate with wrap-around.
    do_reset();
    req[3] = 1'b1; req[700] = 1'b1; req[1023] = 1'b1;
    step(); expect_grant("rot0", 3);
    seq = '{700, 1023, 3, 700};
    for (int k = 0; k < 3; k++) begin
      release_grant("rot"); step();
      expect_grant("rot_next", seq[k]);
    end

    // Grant stays on 700 after its request drops; next goes to 1023.
    do_reset();
    req[700] = 1'b1; req[1023] = 1'b1;
    step(); expect_grant("hold700a", 700);
    req = '0; req[10] = 1'b1; req[1023] = 1'b1;
    step(); step(); expect_grant("hold700a_stable", 700);
    release_grant("hold700a"); step();
    expect_grant("after700_1023", 1023);

    // Same, but without 1023 the rotation wraps to 10.
    do_reset();
    req[700] = 1'b1;
    step(); expect_grant("hold700b", 700);
    req = '0; req[10] = 1'b1;
    step(); expect_grant("hold700b_stable", 700);
    release_grant("hold700b"); step();
    expect_grant("after700_10", 10);

    // done while idle is ignored.
    do_reset();
    done = 1'b1; step(); done = 1'b0;
    chk("idle_done_busy", busy, 0);
    chk("idle_done_valid", gnt_valid, 0);
    step();
    chk("idle_done_busy2", busy, 0);

    // Reset mid-grant drops the grant without moving the pointer.
    do_reset();
    req[42] = 1'b1; step(); expect_grant("pre_rst42", 42);
    rst = 1'b1; step(); rst = 1'b0;
    chk("midrst_valid", gnt_valid, 0);
    chk("midrst_idx", gnt_idx, 0);
    chk_oh("midrst_onehot", gnt_onehot, '0);
    chk("midrst_busy", busy, 0);
    step(); expect_grant("post_rst42", 42);

`ifdef ARB_TIMEOUT_EN
    // Watchdog expiry after TO grant cycles, then done in the limit cycle.
    do_reset();
    req[9] = 1'b1; req[12] = 1'b1;
    step(); expect_grant("to9", 9);
    step(); step(); step();
    expect_grant("to9_cycle4", 9);
    chk("to9_no_pulse_yet", timeout, 0);
    step();
    chk("to9_released", gnt_valid, 0);
    chk("to9_pulse", timeout, 1);
    step(); expect_grant("to_next12", 12);
    chk("to_pulse_cleared", timeout, 0);
    step(); step(); step();
    done = 1'b1; step(); done = 1'b0;
    chk("done_wins_released", gnt_valid, 0);
    chk("done_wins_no_pulse", timeout, 0);
    step(); expect_grant("after12_wrap9", 9);
`else
    // Without the watchdog a grant is held indefinitely.
    do_reset();
    req[9] = 1'b1; req[12] = 1'b1;
    step(); expect_grant("nowd9", 9);
    for (int k = 0; k < 300; k++) step();
    expect_grant("nowd9_held", 9);
    release_grant("nowd9"); step();
    expect_grant("nowd_next12", 12);
`endif

    // Random traffic checked each cycle by the model.
    do_reset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      rst  = ($urandom_range(0, 199) == 0);
      done = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) == 0) begin
        req = '0;
      end else if ($urandom_range(0, 2) == 0) begin
        req = '0;
        for (int b = 0; b < int'($urandom_range(1, 4)); b++) req[$urandom_range(0, N - 1)] = 1'b1;
        if ($urandom_range(0, 7) == 0) req[0] = 1'b1;
        if ($urandom_range(0, 7) == 0) req[N-1] = 1'b1;
      end
      step();
    end
    rst = 1'b0; done = 1'b0; req = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
